// File: rtl/display_pkg.sv
// Codes shared by the 7-segment display path: anode strobes, segment glyphs
// and the scan-decoder state encoding.
package display_pkg;

  localparam logic [3:0] AN_DIG0  = 4'b1110;
  localparam logic [3:0] AN_DIG1  = 4'b1101;
  localparam logic [3:0] AN_DIG2  = 4'b1011;
  localparam logic [3:0] AN_DIG3  = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  // Segment bit order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } slot_t;

  // Maps a one-hot-low anode strobe to its digit slot; blank and multi-hot are not legal slots.
  function automatic slot_t anode_slot(input logic [3:0] an);
    slot_t s;
    s.legal = 1'b1;
    s.idx   = 2'd0;
    case (an)
      AN_DIG0: s.idx = 2'd0;
      AN_DIG1: s.idx = 2'd1;
      AN_DIG2: s.idx = 2'd2;
      AN_DIG3: s.idx = 2'd3;
      default: s.legal = 1'b0;
    endcase
    return s;
  endfunction

  // Forward glyph table used by the display encoder; anything above 9 shows blank.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_to_num.sv
// Inverse of the number-to-segment encoder: segment pattern to BCD nibble,
// with blank mapped to 4'hF and every other unknown glyph flagged illegal.
module seg7_to_num
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: nibble = NIB_BLANK;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors the multiplexed anode/segment bus and rebuilds the 4-digit BCD value
// on display, pulsing num_valid per complete frame and flagging illegal strobes.
module seg_scan_decoder
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  seg,
  output logic [15:0] num,
  output logic        num_valid,
  output logic        code_err,
  output logic        timeout
);

  localparam int            SW         = 8;
  localparam int            TW         = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST   = TW'(FRAME_TIMEOUT - 1);

  logic [3:0]    anode_p0, anode_p1;
  logic [6:0]    seg_p0, seg_p1;
  logic [SW-1:0] settle_cnt, settle_next;
  logic          sample;

  // p0: registered bus copy; p1: its previous value, used only for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_p0   <= AN_BLANK;
      seg_p0     <= SEG_BLANK;
      anode_p1   <= AN_BLANK;
      seg_p1     <= SEG_BLANK;
      settle_cnt <= '0;
    end else begin
      anode_p0   <= anode;
      seg_p0     <= seg;
      anode_p1   <= anode_p0;
      seg_p1     <= seg_p0;
      settle_cnt <= settle_next;
    end
  end

  // Saturating counter makes the sample a single pulse per stable strobe.
  always_comb begin
    if ({anode_p0, seg_p0} != {anode_p1, seg_p1}) begin
      settle_next = '0;
    end else if (settle_cnt == SETTLE_MAX) begin
      settle_next = settle_cnt;
    end else begin
      settle_next = settle_cnt + 1'b1;
    end
    sample = (settle_next == SETTLE_MAX) && (settle_cnt != SETTLE_MAX);
  end

  logic       seg_legal;
  logic [3:0] seg_nib;
  slot_t      slot;
  logic       an_blank;
  logic       capture;
  logic       bad;

  seg7_to_num u_seg7_to_num (
    .seg    (seg_p0),
    .legal  (seg_legal),
    .nibble (seg_nib)
  );

  assign slot     = anode_slot(anode_p0);
  assign an_blank = (anode_p0 == AN_BLANK);
  assign capture  = sample && slot.legal && seg_legal;
  assign bad      = sample && !an_blank && !(slot.legal && seg_legal);

  state_t        state, state_next;
  logic [3:0]    flags, flags_next;
  logic [TW-1:0] tmo_cnt, tmo_next;
  logic [15:0]   shadow, shadow_next;
  logic          complete;
  logic          expire;
  logic          frame_end;

  // p2: frame state and output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flags     <= '0;
      tmo_cnt   <= '0;
      num_valid <= 1'b0;
      code_err  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      flags     <= flags_next;
      tmo_cnt   <= tmo_next;
      num_valid <= complete;
      code_err  <= bad;
      timeout   <= expire;
    end
  end

  // Slots are only trusted under their flag, so the shadow needs no reset.
  always_ff @(posedge clk) begin
    shadow <= shadow_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num <= '0;
    end else if (complete) begin
      num <= shadow;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (capture) state_next = COLLECT;
      end
      COLLECT: begin
        if (bad || (frame_end && !capture)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion beats a same-cycle timeout; a capture on a frame boundary seeds the next frame.
  always_comb begin
    complete    = (state == COLLECT) && (flags == 4'hF);
    expire      = (state == COLLECT) && !complete && (tmo_cnt == TMO_LAST);
    frame_end   = complete || expire;
    flags_next  = frame_end ? 4'h0 : flags;
    shadow_next = shadow;
    tmo_next    = ((state == COLLECT) && !frame_end) ? tmo_cnt + 1'b1 : '0;
    if (bad) begin
      flags_next  = '0;
      shadow_next = '0;
      tmo_next    = '0;
    end else if (capture) begin
      flags_next[slot.idx]                  = 1'b1;
      shadow_next[{slot.idx, 2'b00} +: 4]   = seg_nib;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: tasks queue expected pulses with their
// cycle stamps, a negedge monitor pops and compares them as the DUT pulses.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int TMO    = 50;
  localparam logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  localparam logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [3:0] BLANK_AN = 4'b1111;
  localparam int K_VALID = 0;
  localparam int K_CERR  = 1;
  localparam int K_TMO   = 2;

  typedef struct {
    int          kind;
    logic [15:0] val;
    int          at;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [15:0] num;
  logic        num_valid;
  logic        code_err;
  logic        timeout;

  ev_t exp_q[$];
  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;

  seg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .FRAME_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .anode     (anode),
    .seg       (seg),
    .num       (num),
    .num_valid (num_valid),
    .code_err  (code_err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] pulses;
  ev_t        want;
  always @(negedge clk) begin
    pulses = {timeout, code_err, num_valid};
    for (int k = 0; k < 3; k++) begin
      if (pulses[k]) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL pulse%0d_unexpected: got pulse at cycle %0d (num %h), required none", k, cyc, num);
        end else begin
          want = exp_q.pop_front();
          if (want.kind != k || want.at != cyc || (k == K_VALID && num !== want.val)) begin
            mismatched++;
            $display("FAIL pulse%0d_event: got kind %0d cycle %0d num %h, required kind %0d cycle %0d num %h",
                     k, k, cyc, num, want.kind, want.at, want.val);
          end
        end
      end
    end
  end

  task automatic show(input logic [3:0] an, input logic [6:0] sg, input int hold);
    anode = an;
    seg   = sg;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input logic [15:0] value, input int hold, input bit expect_valid);
    for (int d = 3; d >= 0; d--) begin
      if (d == 0 && expect_valid) exp_q.push_back('{K_VALID, value, cyc + SETTLE + 3});
      show(AN[d], PAT[value[4*d +: 4]], hold);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    anode = BLANK_AN;
    seg   = 7'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (num !== 16'h0000) begin mismatched++; $display("FAIL reset_num: got %h, required 0000", num); end
    compared++;
    if (num_valid !== 1'b0) begin mismatched++; $display("FAIL reset_num_valid: got %b, required 0", num_valid); end
    compared++;
    if (code_err !== 1'b0) begin mismatched++; $display("FAIL reset_code_err: got %b, required 0", code_err); end
    compared++;
    if (timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
  endtask

  task automatic test_scan_1234();
    scan(16'h1234, 8, 1'b1);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h1234) begin mismatched++; $display("FAIL scan1234_num: got %h, required 1234", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scan1234_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_illegal_seg();
    show(AN[3], PAT[1], 8);
    show(AN[2], PAT[2], 8);
    exp_q.push_back('{K_CERR, 16'h0, cyc + SETTLE + 2});
    show(AN[1], 7'b0110000, 8);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h1234) begin mismatched++; $display("FAIL illegal_seg_num: got %h, required 1234", num); end
    scan(16'h0007, 8, 1'b1);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h0007) begin mismatched++; $display("FAIL after_illegal_num: got %h, required 0007", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL illegal_seg_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_short_strobe();
    for (int d = 3; d >= 0; d--) show(AN[d], PAT[6], SETTLE - 1);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h0007) begin mismatched++; $display("FAIL short_strobe_num: got %h, required 0007", num); end
    scan(16'h5959, SETTLE + 1, 1'b1);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h5959) begin mismatched++; $display("FAIL scan5959_num: got %h, required 5959", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL short_strobe_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bad_anode();
    exp_q.push_back('{K_CERR, 16'h0, cyc + SETTLE + 2});
    show(4'b1100, PAT[3], 10);
    show(BLANK_AN, 7'b0, 100);
    compared++;
    if (num !== 16'h5959) begin mismatched++; $display("FAIL bad_anode_num: got %h, required 5959", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL bad_anode_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back('{K_TMO, 16'h0, cyc + SETTLE + 2 + TMO});
    show(AN[0], PAT[1], 8);
    show(AN[1], PAT[2], 8);
    show(BLANK_AN, 7'b0, 70);
    compared++;
    if (num !== 16'h5959) begin mismatched++; $display("FAIL timeout_num: got %h, required 5959", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL timeout_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_boundary();
    int t;
    // Fourth digit completes on the very cycle the timeout would fire.
    show(AN[3], PAT[4], 16);
    show(AN[2], PAT[3], 16);
    show(AN[1], PAT[2], 17);
    exp_q.push_back('{K_VALID, 16'h4321, cyc + SETTLE + 3});
    show(AN[0], PAT[1], 8);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h4321) begin mismatched++; $display("FAIL boundary_num: got %h, required 4321", num); end
    // Two cycles later: the frame expires and the late digit starts a fresh frame that expires too.
    t = cyc;
    exp_q.push_back('{K_TMO, 16'h0, t + SETTLE + 2 + TMO});
    show(AN[3], PAT[9], 16);
    show(AN[2], PAT[8], 16);
    show(AN[1], PAT[7], 19);
    exp_q.push_back('{K_TMO, 16'h0, cyc + SETTLE + 2 + TMO});
    show(AN[0], PAT[6], 8);
    show(BLANK_AN, 7'b0, 70);
    compared++;
    if (num !== 16'h4321) begin mismatched++; $display("FAIL late_boundary_num: got %h, required 4321", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL boundary_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    show(AN[3], PAT[1], 8);
    show(AN[2], PAT[2], 8);
    show(AN[1], PAT[3], 8);
    reset = 1'b1;
    anode = BLANK_AN;
    seg   = 7'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (num !== 16'h0000) begin mismatched++; $display("FAIL midframe_reset_num: got %h, required 0000", num); end
    show(BLANK_AN, 7'b0, 70);
    scan(16'h8888, 8, 1'b1);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h8888) begin mismatched++; $display("FAIL scan8888_num: got %h, required 8888", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL midframe_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    scan(16'h1234, 6, 1'b1);
    scan(16'h5678, 6, 1'b1);
    show(BLANK_AN, 7'b0, 10);
    compared++;
    if (num !== 16'h5678) begin mismatched++; $display("FAIL back_to_back_num: got %h, required 5678", num); end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL back_to_back_pending: got %0d outstanding events, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_illegal_seg();
    test_short_strobe();
    test_bad_anode();
    test_timeout();
    test_boundary();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
